// File: rtl/board_pkg.sv
// Shared mode encoding, reset constants and pattern helpers for the board LED demo.
package board_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_COUNT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    localparam logic [7:0] ROT_INIT  = 8'h01;
    localparam logic [7:0] BPOS_INIT = 8'h01;

    // Bit positions of the control fields inside the synchronized switch word.
    localparam int SW_MODE_LO = 0;
    localparam int SW_MODE_HI = 1;
    localparam int SW_PAUSE   = 2;

    typedef struct packed {
        logic [7:0] bpos;
        logic       dir;   // 0 = moving left, 1 = moving right
    } bounce_t;

    localparam bounce_t BOUNCE_INIT = '{bpos: BPOS_INIT, dir: 1'b0};

    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    // Direction flips on the same step that lands on an end position.
    function automatic bounce_t bounce_next(input bounce_t cur);
        bounce_t nxt;
        nxt.bpos = cur.dir ? (cur.bpos >> 1) : (cur.bpos << 1);
        nxt.dir  = cur.dir;
        if (nxt.bpos == 8'h80) begin
            nxt.dir = 1'b1;
        end else if (nxt.bpos == 8'h01) begin
            nxt.dir = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/board_tick.sv
// Free-running prescaler; tick is high for the last cycle of every TICK_DIV-cycle period.
module board_tick #(
    parameter int unsigned TICK_DIV = 8
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/board_top.sv
// LED demo top: synchronizes the switches and drives a switch-selected animated pattern.
module board_top
    import board_pkg::*;
#(
    parameter int unsigned TICK_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw,
    output logic [7:0] led
);

    logic [7:0] sw_meta_q;
    logic [7:0] sw_s_q;
    logic       tick;
    logic       pause;
    logic       step;
    mode_e      mode;

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rot_q, rot_d;
    bounce_t    bnc_q, bnc_d;
    logic [7:0] led_q, led_d;

    board_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Two-flop synchronizer: sw is asynchronous, only sw_s_q is used downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_s_q    <= sw_meta_q;
        end
    end

    assign mode  = mode_e'(sw_s_q[SW_MODE_HI:SW_MODE_LO]);
    assign pause = sw_s_q[SW_PAUSE];
    assign step  = tick & ~pause;

    // Only the selected pattern advances; the others keep their position.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        rot_d = rot_q;
        bnc_d = bnc_q;
        if (step) begin
            case (mode)
                MODE_COUNT:  cnt_d = cnt_q + 8'd1;
                MODE_ROTATE: rot_d = rotl8(rot_q);
                MODE_BOUNCE: bnc_d = bounce_next(bnc_q);
                default:     ;
            endcase
        end
    end

    always_comb begin
        led_d = sw_s_q;
        case (mode)
            MODE_STATIC: led_d = sw_s_q;
            MODE_COUNT:  led_d = cnt_q;
            MODE_ROTATE: led_d = rot_q;
            MODE_BOUNCE: led_d = bnc_q.bpos;
            default:     led_d = sw_s_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'h00;
            rot_q <= ROT_INIT;
            bnc_q <= BOUNCE_INIT;
            led_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
            rot_q <= rot_d;
            bnc_q <= bnc_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_board_top.sv
// Self-checking bench for board_top: directed vectors, hand sequences and randomized switches.
module tb_board_top;

    localparam int TICK_DIV = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw    = 8'h01;
    logic [7:0] led;

    board_top #(
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sw   (sw),
        .led  (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each pattern is tracked as a count of steps taken in its mode.
    int         m_pre = 0;
    logic [7:0] m_s1  = 8'h00;
    logic [7:0] m_s2  = 8'h00;
    logic [7:0] m_led = 8'h00;
    int         m_cnt = 0;
    int         m_rot = 0;
    int         m_bnc = 0;

    function automatic logic [7:0] model_view(input logic [7:0] s);
        int b;
        case (s[1:0])
            2'b00:   return s;
            2'b01:   return 8'(m_cnt % 256);
            2'b10:   return 8'(1 << (m_rot % 8));
            default: begin
                b = m_bnc % 14;
                return 8'(1 << ((b < 8) ? b : 14 - b));
            end
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0] nxt_led;
        if (reset) begin
            m_pre = 0; m_s1 = 8'h00; m_s2 = 8'h00; m_led = 8'h00;
            m_cnt = 0; m_rot = 0; m_bnc = 0;
        end else begin
            nxt_led = model_view(m_s2);
            if (m_pre == TICK_DIV - 1 && !m_s2[2]) begin
                case (m_s2[1:0])
                    2'b01:   m_cnt++;
                    2'b10:   m_rot++;
                    2'b11:   m_bnc++;
                    default: ;
                endcase
            end
            m_pre = (m_pre + 1) % TICK_DIV;
            m_s2  = m_s1;
            m_s1  = sw;
            m_led = nxt_led;
        end
    endtask

    task automatic run_edges(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check({name, "_model"}, led, m_led);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] sw;
        int         edges;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] bseq[16];
    int         hold;

    initial begin
        vecs.push_back('{1'b0, 8'h01,  8, 8'h00, "cnt_before_first_step"});
        vecs.push_back('{1'b0, 8'h01,  1, 8'h01, "cnt_first_step"});
        vecs.push_back('{1'b0, 8'h01,  8, 8'h02, "cnt_second_step"});
        vecs.push_back('{1'b0, 8'h05, 24, 8'h02, "cnt_paused"});
        vecs.push_back('{1'b0, 8'h01,  8, 8'h03, "cnt_resume"});
        vecs.push_back('{1'b0, 8'hA8,  2, 8'h03, "static_lat2"});
        vecs.push_back('{1'b0, 8'hA8,  1, 8'hA8, "static_lat3"});
        vecs.push_back('{1'b0, 8'h50,  2, 8'hA8, "static_toggle_lat2"});
        vecs.push_back('{1'b0, 8'h50,  1, 8'h50, "static_toggle_lat3"});
        vecs.push_back('{1'b0, 8'h02,  2, 8'h50, "rot_lat2"});
        vecs.push_back('{1'b0, 8'h02,  1, 8'h01, "rot_initial"});
        vecs.push_back('{1'b0, 8'h02,  7, 8'h02, "rot_step1"});
        vecs.push_back('{1'b0, 8'h02,  8, 8'h04, "rot_step2"});
        vecs.push_back('{1'b1, 8'h02,  1, 8'h00, "reset_mid_run"});
        vecs.push_back('{1'b0, 8'h02,  2, 8'h00, "post_reset_sync"});
        vecs.push_back('{1'b0, 8'h02,  6, 8'h01, "post_reset_rot_init"});
        vecs.push_back('{1'b0, 8'h02,  1, 8'h02, "prescaler_restart"});

        bseq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        // Reset held for two edges with counter mode on the switches.
        reset = 1'b1;
        sw    = 8'h01;
        run_edges(2, "reset_held");
        check("reset_led", led, 8'h00);
        check("reset_cnt", dut.cnt_q, 8'h00);
        check("reset_rot", dut.rot_q, 8'h01);
        check("reset_bpos", dut.bnc_q.bpos, 8'h01);
        check("reset_dir", {7'd0, dut.bnc_q.dir}, 8'h00);

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            sw    = vecs[i].sw;
            run_edges(vecs[i].edges, vecs[i].name);
            check(vecs[i].name, led, vecs[i].exp);
            if (vecs[i].rst) begin
                check("prescaler_after_reset", 8'(dut.u_tick.count_q), 8'h00);
            end
        end

        // Bounce: each end position is visible for exactly one step.
        reset = 1'b1;
        run_edges(1, "bounce_reset");
        reset = 1'b0;
        sw    = 8'h03;
        run_edges(8, "bounce_start");
        for (int k = 1; k < 16; k++) begin
            run_edges(1, "bounce_step");
            check($sformatf("bounce_first_%0d", k), led, bseq[k]);
            run_edges(7, "bounce_hold");
            check($sformatf("bounce_last_%0d", k), led, bseq[k]);
        end

        // Counter wrap after 256 steps.
        reset = 1'b1;
        run_edges(1, "wrap_reset");
        reset = 1'b0;
        sw    = 8'h01;
        run_edges(8 * 255 + 1, "wrap_run");
        check("cnt_ff", led, 8'hFF);
        run_edges(8, "wrap_step");
        check("cnt_wrap", led, 8'h00);

        // Randomized switch settings, pause mostly off, occasional reset.
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 31) == 0) begin
                reset = 1'b1;
                run_edges($urandom_range(1, 2), "rand_reset");
                reset = 1'b0;
            end
            sw    = 8'($urandom);
            sw[2] = ($urandom_range(0, 3) == 0);
            hold  = $urandom_range(1, 40);
            run_edges(hold, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
